i2c_byte_ctrl: RTL and testbench

//  I2C master byte-level controller. Sequences open-drain SCL/SDA drivers to issue

---
 rtl/i2c_byte_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_i2c_byte_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_byte_ctrl
// Single-master I2C byte-level controller. A host issues START, WRITE byte,
// READ byte and STOP commands; the controller sequences the open-drain pad
// enables for SCL and SDA. There is no clock stretching and no arbitration.
//
// Every SCL bit is split into four phases, and each phase lasts CLK_DIV
// clk_in cycles.
//
// Ports
//   clk_in     system clock (rising edge)
//   rst_n      asynchronous reset, active low
//   cmd_valid  command request
//   cmd_ready  command can be accepted (high only while idle)
//   cmd        00 START, 01 WRITE, 10 READ, 11 STOP
//   tx_data    WRITE byte, sent MSB first
//   ack_in     ACK bit driven after a READ (0 = ACK, 1 = NACK)
//   rx_data    byte captured by the last READ
//   rx_ack     ACK bit sampled after the last WRITE (0 = slave ACK)
//   done       one-cycle pulse when a command completes
//   busy       a command is executing
//   scl_oe     1 = pull SCL low
//   sda_oe     1 = pull SDA low
//   sda_in     SDA pad value (asynchronous)
// ---------------------------------------------------------------------------
module i2c_byte_ctrl #(
   parameter int CLK_DIV = 250
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd,
   input  logic [7:0] tx_data,
   input  logic       ack_in,
   output logic [7:0] rx_data,
   output logic       rx_ack,
   output logic       done,
   output logic       busy,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       sda_in
);

   localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);
   localparam logic [QW-1:0] Q_PEN  = QW'(CLK_DIV - 2);

   localparam logic [1:0] CMD_START = 2'b00;
   localparam logic [1:0] CMD_WRITE = 2'b01;
   localparam logic [1:0] CMD_READ  = 2'b10;
   localparam logic [1:0] CMD_STOP  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_BIT    = 3'd2,
      ST_ACKBIT = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   state_t          state_r, state_n;
   logic [QW-1:0]   qcnt_r, qcnt_n;
   logic [1:0]      ph_r, ph_n;
   logic [2:0]      bit_r, bit_n;
   logic [1:0]      cmd_r, cmd_n;
   logic [7:0]      tx_r, tx_n;
   logic            ack_r, ack_n;
   logic [7:0]      shift_r, shift_n;
   logic [7:0]      rx_data_r, rx_data_n;
   logic            rx_ack_r, rx_ack_n;
   logic            done_r, done_n;
   logic            scl_oe_r, scl_n;
   logic            sda_oe_r, sda_n;
   logic            cmd_ready_r, busy_r;
   logic            sda_s1_r, sda_s2_r;
   logic            q_last;

   assign q_last    = (qcnt_r == Q_LAST);
   assign cmd_ready = cmd_ready_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign rx_data   = rx_data_r;
   assign rx_ack    = rx_ack_r;
   assign scl_oe    = scl_oe_r;
   assign sda_oe    = sda_oe_r;

   // Two-flop synchronizer for the asynchronous SDA pad input
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sda_s1_r <= 1'b1;
         sda_s2_r <= 1'b1;
      end else begin
         sda_s1_r <= sda_in;
         sda_s2_r <= sda_s1_r;
      end
   end

   // Next-state logic: command acceptance, quarter/phase/bit sequencing, and SDA sampling
   always_comb begin
      state_n   = state_r;
      qcnt_n    = qcnt_r;
      ph_n      = ph_r;
      bit_n     = bit_r;
      cmd_n     = cmd_r;
      tx_n      = tx_r;
      ack_n     = ack_r;
      shift_n   = shift_r;
      rx_data_n = rx_data_r;
      rx_ack_n  = rx_ack_r;
      done_n    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid) begin
               cmd_n  = cmd;
               tx_n   = tx_data;
               ack_n  = ack_in;
               qcnt_n = '0;
               ph_n   = 2'd0;
               bit_n  = 3'd7;
               case (cmd)
                  CMD_START: state_n = ST_START;
                  CMD_STOP:  state_n = ST_STOP;
                  default:   state_n = ST_BIT;
               endcase
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_START, ST_BIT, ST_ACKBIT, ST_STOP: begin
            if (q_last) begin
               qcnt_n = '0;
               ph_n   = ph_r + 2'd1;
               if (ph_r == 2'd3) begin
                  if (state_r == ST_BIT) begin
                     if (bit_r == 3'd0) begin
                        state_n = ST_ACKBIT;
                     end else begin
                        bit_n = bit_r - 3'd1;
                     end
                  end else begin
                     state_n = ST_IDLE;
                  end
               end else begin
                  state_n = state_r;
               end
            end else begin
               qcnt_n = qcnt_r + {{(QW-1){1'b0}}, 1'b1};
            end
            // SDA is sampled in the last cycle of phase 2, while SCL is high.
            if (q_last && (ph_r == 2'd2)) begin
               if ((state_r == ST_BIT) && (cmd_r == CMD_READ)) begin
                  shift_n = {shift_r[6:0], sda_s2_r};
               end else if ((state_r == ST_ACKBIT) && (cmd_r == CMD_WRITE)) begin
                  rx_ack_n = sda_s2_r;
               end else begin
                  shift_n = shift_r;
               end
            end else begin
               shift_n = shift_r;
            end
            // The host-visible byte changes only once the READ has finished.
            if (q_last && (ph_r == 2'd3) && (state_r == ST_ACKBIT) && (cmd_r == CMD_READ)) begin
               rx_data_n = shift_r;
            end else begin
               rx_data_n = rx_data_r;
            end
            // done is registered, so it is raised one cycle before the final cycle.
            done_n = (ph_r == 2'd3) && (qcnt_r == Q_PEN) && (state_r != ST_BIT);
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // Pad-enable targets derived from the upcoming state so outputs come straight from flops
   always_comb begin
      scl_n = scl_oe_r;
      sda_n = sda_oe_r;
      case (state_n)
         ST_IDLE: begin
            // After a byte, SCL is held low and SDA is released.
            if (state_r == ST_ACKBIT) begin
               sda_n = 1'b0;
            end else begin
               sda_n = sda_oe_r;
            end
         end
         ST_START: begin
            case (ph_n)
               2'd0:    begin scl_n = 1'b0; sda_n = 1'b0; end
               2'd1:    begin scl_n = 1'b0; sda_n = 1'b1; end
               default: begin scl_n = 1'b1; sda_n = 1'b1; end
            endcase
         end
         ST_BIT: begin
            scl_n = (ph_n == 2'd0) || (ph_n == 2'd3);
            sda_n = (cmd_n == CMD_WRITE) ? ~tx_n[bit_n] : 1'b0;
         end
         ST_ACKBIT: begin
            scl_n = (ph_n == 2'd0) || (ph_n == 2'd3);
            sda_n = (cmd_n == CMD_WRITE) ? 1'b0 : ~ack_n;
         end
         ST_STOP: begin
            case (ph_n)
               2'd0:    begin scl_n = 1'b1; sda_n = 1'b1; end
               2'd1:    begin scl_n = 1'b0; sda_n = 1'b1; end
               default: begin scl_n = 1'b0; sda_n = 1'b0; end
            endcase
         end
         default: begin
            scl_n = 1'b0;
            sda_n = 1'b0;
         end
      endcase
   end

   // State, counter, data and output registers
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         qcnt_r      <= '0;
         ph_r        <= 2'd0;
         bit_r       <= 3'd0;
         cmd_r       <= 2'b00;
         tx_r        <= 8'h00;
         ack_r       <= 1'b0;
         shift_r     <= 8'h00;
         rx_data_r   <= 8'h00;
         rx_ack_r    <= 1'b1;
         done_r      <= 1'b0;
         scl_oe_r    <= 1'b0;
         sda_oe_r    <= 1'b0;
         cmd_ready_r <= 1'b1;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_n;
         qcnt_r      <= qcnt_n;
         ph_r        <= ph_n;
         bit_r       <= bit_n;
         cmd_r       <= cmd_n;
         tx_r        <= tx_n;
         ack_r       <= ack_n;
         shift_r     <= shift_n;
         rx_data_r   <= rx_data_n;
         rx_ack_r    <= rx_ack_n;
         done_r      <= done_n;
         scl_oe_r    <= scl_n;
         sda_oe_r    <= sda_n;
         cmd_ready_r <= (state_n == ST_IDLE);
         busy_r      <= (state_n != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2c_byte_ctrl
// Self-checking bench for i2c_byte_ctrl with CLK_DIV=4. It models an
// open-drain bus with pull-ups and includes a simple slave. A reference model
// derives the expected results from the command rules:
//   - latency,
//   - bits seen on each SCL rise,
//   - how many cycles each line is pulled low,
//   - START/STOP conditions,
//   - idle line levels,
//   - rx_data and rx_ack.
// ---------------------------------------------------------------------------
module tb_i2c_byte_ctrl;
   localparam int CLK_DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd;
   logic [7:0] tx_data;
   logic       ack_in;
   logic [7:0] rx_data;
   logic       rx_ack;
   logic       done;
   logic       busy;
   logic       scl_oe;
   logic       sda_oe;
   logic       slv_drive = 1'b0;

   wire scl_w = ~scl_oe;
   wire sda_w = ~(sda_oe | slv_drive);

   i2c_byte_ctrl #(.CLK_DIV(CLK_DIV)) dut (
      .clk_in(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd(cmd), .tx_data(tx_data), .ack_in(ack_in), .rx_data(rx_data),
      .rx_ack(rx_ack), .done(done), .busy(busy), .scl_oe(scl_oe),
      .sda_oe(sda_oe), .sda_in(sda_w)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // slave / monitor state
   int         seq = 0;
   int         mon_seq = 0;
   logic [1:0] slv_mode = 2'd0;   // 0 none, 1 write target, 2 read source
   logic [7:0] slv_byte = 8'h00;
   logic       slv_ack  = 1'b0;
   int         rise_cnt = 0;
   logic       bits_q[$];
   int         start_ev = 0, stop_ev = 0, sda_hi = 0, scl_hi = 0;
   logic       prev_scl = 1'b1, prev_sda = 1'b1;

   // reference model state
   logic [7:0] exp_rx_data;
   logic       exp_rx_ack;

   // Cycle counter
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Bus monitor and slave model, sampled on the falling clock edge
   initial forever begin
      @(negedge clk);
      if (mon_seq != seq) begin
         mon_seq  = seq;
         rise_cnt = 0;
         bits_q.delete();
         start_ev = 0; stop_ev = 0; sda_hi = 0; scl_hi = 0;
         slv_drive = (slv_mode == 2'd2) ? ~slv_byte[7] : 1'b0;
      end
      if (prev_scl && scl_w) begin
         if (prev_sda && !sda_w) start_ev++;
         else if (!prev_sda && sda_w) stop_ev++;
      end
      if (!prev_scl && scl_w) begin
         bits_q.push_back(sda_w);
         rise_cnt++;
      end
      if (prev_scl && !scl_w) begin
         if (slv_mode == 2'd2) slv_drive = (rise_cnt < 8) ? ~slv_byte[7 - rise_cnt] : 1'b0;
         else if (slv_mode == 2'd1) slv_drive = (rise_cnt == 8) && slv_ack;
         else slv_drive = 1'b0;
      end
      if (busy === 1'b1) begin
         if (sda_oe) sda_hi++;
         if (scl_oe) scl_hi++;
      end
      prev_scl = scl_w;
      prev_sda = sda_w;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one command at a falling edge with cmd_ready high. The task
   // returns at the falling edge one cycle after done.
   task automatic run_cmd(input logic [1:0] c, input logic [7:0] tx, input logic ak,
                          input logic sack, input logic [7:0] sbyte, input bit keep);
      int t, n, k, exp_n, exp_sda, exp_scl, zeros;
      logic [31:0] exp_bits, got_bits;
      n = (c == 2'b00 || c == 2'b11) ? 4 : 36;
      check("ready_before", {31'd0, cmd_ready}, 32'd1);
      cmd = c; tx_data = tx; ack_in = ak; cmd_valid = 1'b1;
      slv_mode = (c == 2'b01) ? 2'd1 : ((c == 2'b10) ? 2'd2 : 2'd0);
      slv_byte = sbyte; slv_ack = sack;
      seq++;
      t = cyc;
      @(negedge clk);
      check("busy_after_accept", {30'd0, busy, cmd_ready}, 32'd2);
      if (!keep) cmd_valid = 1'b0;
      k = 0;
      while (done !== 1'b1 && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("done_latency", cyc - t, n * CLK_DIV);
      @(negedge clk);
      check("idle_after_done", {29'd0, done, cmd_ready, busy}, 32'd2);
      // reference expectations
      zeros = 0;
      for (int i = 0; i < 8; i++) if (!tx[i]) zeros++;
      case (c)
         2'b00: begin exp_n = 0; exp_bits = 0; exp_sda = 3 * CLK_DIV; exp_scl = 2 * CLK_DIV; end
         2'b11: begin exp_n = 1; exp_bits = 0; exp_sda = 2 * CLK_DIV; exp_scl = CLK_DIV; end
         2'b01: begin
            exp_n = 9; exp_bits = {23'd0, tx, ~sack};
            exp_sda = 4 * CLK_DIV * zeros; exp_scl = 18 * CLK_DIV;
            exp_rx_ack = ~sack;
         end
         default: begin
            exp_n = 9; exp_bits = {23'd0, sbyte, ak};
            exp_sda = ak ? 0 : 4 * CLK_DIV; exp_scl = 18 * CLK_DIV;
            exp_rx_data = sbyte;
         end
      endcase
      got_bits = 0;
      foreach (bits_q[i]) got_bits = {got_bits[30:0], bits_q[i]};
      check("rise_count", bits_q.size(), exp_n);
      check("rise_bits", got_bits, exp_bits);
      check("sda_low_cycles", sda_hi, exp_sda);
      check("scl_low_cycles", scl_hi, exp_scl);
      check("start_cond", start_ev, (c == 2'b00) ? 1 : 0);
      check("stop_cond", stop_ev, (c == 2'b11) ? 1 : 0);
      check("idle_lines", {30'd0, scl_oe, sda_oe},
            {30'd0, (c != 2'b11), (c == 2'b00)});
      check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx_data});
      check("rx_ack", {31'd0, rx_ack}, {31'd0, exp_rx_ack});
   endtask

   initial begin
      logic [7:0] r8;
      int nops;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd = 2'b00; tx_data = 8'h00; ack_in = 1'b0;
      exp_rx_data = 8'h00; exp_rx_ack = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_state", {20'd0, scl_oe, sda_oe, cmd_ready, busy, done, rx_ack, 2'd0, rx_data[3:0]},
            {20'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'h0});
      check("reset_rx_data", {24'd0, rx_data}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset in bit index 3 of a WRITE aborts immediately
      cmd = 2'b01; tx_data = 8'hC3; cmd_valid = 1'b1; slv_mode = 2'd1; slv_ack = 1'b1; seq++;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (65) @(negedge clk);
      check("mid_write_scl", {30'd0, scl_oe, busy}, 32'd3);
      rst_n = 1'b0;
      #1;
      check("async_abort", {28'd0, scl_oe, sda_oe, cmd_ready, busy}, 32'd2);
      check("async_abort_rx_ack", {31'd0, rx_ack}, 32'd1);
      @(negedge clk);
      slv_mode = 2'd0; seq++;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      exp_rx_data = 8'h00; exp_rx_ack = 1'b1;

      // Directed commands
      run_cmd(2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);   // START
      run_cmd(2'b01, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0);   // WRITE with slave ACK
      run_cmd(2'b01, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);   // WRITE, no slave
      run_cmd(2'b10, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0);   // READ 0x3C, NACK
      run_cmd(2'b11, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);   // STOP

      // Back-to-back, cmd_valid held high
      r8 = 8'($urandom);
      run_cmd(2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
      run_cmd(2'b01, 8'h50, 1'b0, 1'b1, 8'h00, 1'b1);
      run_cmd(2'b10, 8'h00, 1'b0, 1'b0, r8,    1'b1);
      run_cmd(2'b11, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("no_reaccept", {30'd0, cmd_ready, busy}, 32'd2);

      // Randomized transactions
      for (int it = 0; it < 5; it++) begin
         run_cmd(2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
         nops = $urandom_range(1, 3);
         for (int j = 0; j < nops; j++) begin
            if ($urandom_range(0, 1) == 0)
               run_cmd(2'b01, 8'($urandom), 1'b0, 1'($urandom), 8'h00, 1'b0);
            else
               run_cmd(2'b10, 8'h00, 1'($urandom), 1'b0, 8'($urandom), 1'b0);
         end
         run_cmd(2'b11, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
